// File: rtl/mem_readback_pkg.sv
// Shared types and constants for the memory readback sweeper.
package mem_readback_pkg;

   localparam int ADDR_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_readback_if.sv
// Memory read port plus output stream of the readback sweeper.
// master = the sweeper, slave = memory/consumer side.
interface mem_readback_if
   import mem_readback_pkg::*;
#(
   parameter int WID_MEM = 128
) ();

   logic [ADDR_W-1:0]  raddr;
   logic [WID_MEM-1:0] rdata;
   logic               out_valid;
   logic               out_ready;
   logic [WID_MEM-1:0] out_data;
   logic [ADDR_W-1:0]  out_addr;

   modport master (
      output raddr,
      input  rdata,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_addr
   );

   modport slave (
      input  raddr,
      output rdata,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_addr
   );

endinterface

// File: rtl/mem_readback_fifo2.sv
// Two-entry FIFO holding returned memory words (with their addresses)
// until the consumer accepts them. Caller guarantees no push when full
// and no pop when empty; flush empties it without touching storage.
module rb_fifo2 #(
   parameter int WID = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   input  logic           push,
   input  logic [WID-1:0] push_data,
   input  logic           pop,
   output logic [1:0]     count,
   output logic [WID-1:0] head
);

   logic [WID-1:0] slot [2];
   logic           rd_ptr;
   logic           wr_ptr;

   // Storage, pointers and occupancy; flush drops all entries at once.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count   <= 2'd0;
         slot[0] <= '0;
         slot[1] <= '0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head = slot[rd_ptr];

endmodule

// File: rtl/mem_readback.sv
// Sweeps addresses 0..DEPTH_MEM-1 of a 1-cycle-latency memory and streams
// each word with its address under valid/ready backpressure, accumulating
// an XOR checksum of accepted words. Reads are credit-limited so the
// 2-entry FIFO can always absorb every word already requested.
module mem_readback
   import mem_readback_pkg::*;
#(
   parameter int              WID_MEM   = 128,
   parameter longint unsigned DEPTH_MEM = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   mem_readback_if.master      bus,
   output logic                busy,
   output logic                done,
   output logic [WID_MEM-1:0]  checksum
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 64'd1);

   state_t                      state;
   state_t                      state_nxt;
   logic [ADDR_W-1:0]           addr;
   logic [ADDR_W-1:0]           raddr_q;
   logic [ADDR_W-1:0]           addr_p1;
   logic                        vld_p1;
   logic                        issue;
   logic                        pop;
   logic [1:0]                  count;
   logic [2:0]                  occupancy;
   logic [2:0]                  allowance;
   logic [WID_MEM+ADDR_W-1:0]   head;

   // Credit: issue only while (fifo + in-flight - pop) leaves a free slot.
   assign pop       = bus.out_valid & bus.out_ready;
   assign occupancy = {1'b0, count} + {2'b0, vld_p1};
   assign allowance = 3'd2 + {2'b0, pop};
   assign issue     = (state == READ) && !abort && (occupancy < allowance);

   assign bus.raddr                 = issue ? addr : raddr_q;
   assign bus.out_valid             = (count != 2'd0);
   assign {bus.out_addr, bus.out_data} = head;

   assign busy = (state == READ) || (state == DRAIN);
   assign done = (state == DONE) && !abort;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides everything except reset.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (issue && (addr == LAST_ADDR)) state_nxt = DRAIN;
            DRAIN:   if (!vld_p1 && ((count == 2'd0) || ((count == 2'd1) && pop)))
                        state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Issue address, in-flight tracking and checksum accumulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         addr     <= '0;
         raddr_q  <= '0;
         addr_p1  <= '0;
         vld_p1   <= 1'b0;
         checksum <= '0;
      end else begin
         vld_p1 <= issue;
         if (issue) begin
            raddr_q <= addr;
            addr_p1 <= addr;
            addr    <= addr + 32'd1;
         end
         if ((state == IDLE) && start && !abort) begin
            addr     <= '0;
            checksum <= '0;
         end else if (pop) begin
            checksum <= checksum ^ bus.out_data;
         end
      end
   end

   rb_fifo2 #(
      .WID(WID_MEM + ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (abort),
      .push      (vld_p1),
      .push_data ({addr_p1, bus.rdata}),
      .pop       (pop),
      .count     (count),
      .head      (head)
   );

endmodule

// File: tb/tb_mem_readback.sv
// Bench for mem_readback: 128-word sweeps under several backpressure
// patterns, abort/restart, start+abort, a 1-word instance and mid-sweep reset.
module tb_mem_readback;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic         abort;
   logic         start2;
   logic         abort2;
   logic         busy;
   logic         done;
   logic         busy2;
   logic         done2;
   logic [127:0] checksum;
   logic [127:0] checksum2;

   int n_assert = 0;
   int n_fail   = 0;

   logic [127:0] ram  [128];
   logic [127:0] ram2 [1];

   mem_readback_if #(.WID_MEM(128)) bus  ();
   mem_readback_if #(.WID_MEM(128)) bus2 ();

   mem_readback #(.WID_MEM(128), .DEPTH_MEM(128)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .bus      (bus),
      .busy     (busy),
      .done     (done),
      .checksum (checksum)
   );

   mem_readback #(.WID_MEM(128), .DEPTH_MEM(1)) dut2 (
      .clk      (clk),
      .reset    (reset),
      .start    (start2),
      .abort    (abort2),
      .bus      (bus2),
      .busy     (busy2),
      .done     (done2),
      .checksum (checksum2)
   );

   always #5 clk = ~clk;

   // Memory models with one cycle of read latency.
   always @(posedge clk) begin
      bus.rdata  <= ram[bus.raddr[6:0]];
      bus2.rdata <= ram2[0];
   end

   function automatic logic [127:0] mem_word(input int i);
      return 128'(i);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_raddr"},     128'(bus.raddr),     128'(0));
      chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_out_data"},  bus.out_data,        128'(0));
      chk({tag, "_out_addr"},  128'(bus.out_addr),  128'(0));
      chk({tag, "_busy"},      128'(busy),          128'(0));
      chk({tag, "_done"},      128'(done),          128'(0));
      chk({tag, "_checksum"},  checksum,            128'(0));
   endtask

   // mode 0: ready=1; 1: ready toggles 1,0,...; 2: random ready and start noise;
   // 3: ready=0 for the first 20 cycles. abort_at>=0 aborts when that word is at the head.
   task automatic sweep(input int mode, input int abort_at);
      int           c;
      int           idx;
      int           first_v;
      int           n_done;
      int           done_at;
      int           occ;
      logic [127:0] cs;
      logic [127:0] pd;
      logic [31:0]  pa;
      logic         pv;
      logic         pr;
      logic         r;
      logic         aborted;
      c = 0; idx = 0; first_v = -1; n_done = 0; done_at = -1;
      cs = '0; pd = '0; pa = '0; pv = 1'b0; pr = 1'b0; aborted = 1'b0;
      start = 1'b1; abort = 1'b0; bus.out_ready = 1'b0;
      tick();
      start = 1'b0;
      while (c < 400) begin
         if (bus.out_valid && first_v < 0) first_v = c;
         if (done) begin
            n_done++;
            if (done_at < 0) done_at = c;
         end
         if (pv && !pr) begin
            chk("stall_valid", 128'(bus.out_valid), 128'(1));
            chk("stall_data",  bus.out_data,        pd);
            chk("stall_addr",  128'(bus.out_addr),  128'(pa));
         end
         occ = int'(dut.u_fifo.count) + int'(dut.vld_p1);
         chk("outstanding_le_2", 128'(occ <= 2), 128'(1));
         if (mode == 3 && c == 19) begin
            chk("stall20_raddr",     128'(bus.raddr),     128'(1));
            chk("stall20_out_valid", 128'(bus.out_valid), 128'(1));
            chk("stall20_out_addr",  128'(bus.out_addr),  128'(0));
         end
         if (done_at >= 0 && c >= done_at + 3) break;
         case (mode)
            0:       r = 1'b1;
            1:       r = (c % 2 == 0);
            2:       r = 1'($urandom_range(0, 1));
            default: r = (c >= 20);
         endcase
         start = (mode == 2 && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (abort_at >= 0 && idx == abort_at && bus.out_valid) begin
            abort = 1'b1;
            r     = 1'b0;
         end
         bus.out_ready = r;
         if (bus.out_valid && r) begin
            chk("word_addr", 128'(bus.out_addr), 128'(idx));
            chk("word_data", bus.out_data,       mem_word(idx));
            cs = cs ^ mem_word(idx);
            idx++;
         end
         pv = bus.out_valid; pr = r; pd = bus.out_data; pa = bus.out_addr;
         tick();
         c++;
         if (abort) begin
            aborted = 1'b1;
            abort   = 1'b0;
            start   = 1'b0;
            break;
         end
      end
      start = 1'b0;
      bus.out_ready = 1'b0;
      if (aborted) begin
         chk("abort_busy",      128'(busy),          128'(0));
         chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
         chk("abort_done",      128'(done),          128'(0));
         chk("abort_checksum",  checksum,            cs);
         n_done = 0;
         for (int k = 0; k < 5; k++) begin
            if (done) n_done++;
            tick();
         end
         chk("abort_no_done", 128'(n_done), 128'(0));
         chk("abort_idle",    128'(busy),   128'(0));
      end else begin
         chk("done_seen",      128'(done_at >= 0), 128'(1));
         chk("done_once",      128'(n_done),       128'(1));
         chk("word_count",     128'(idx),          128'(128));
         chk("sweep_checksum", checksum,           cs);
         chk("idle_after",     128'(busy),         128'(0));
         if (mode == 0) begin
            chk("first_valid_cycle", 128'(first_v), 128'(2));
            chk("done_cycle",        128'(done_at), 128'(130));
         end
      end
   endtask

   initial begin
      int           n_done2;
      int           done_at2;
      int           words2;
      logic [127:0] cs2;
      for (int i = 0; i < 128; i++) ram[i] = mem_word(i);
      ram2[0] = 128'hA5;
      reset = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0; abort2 = 1'b0;
      bus.out_ready = 1'b0; bus2.out_ready = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      reset = 1'b0;
      tick();
      chk_reset_outputs("post_reset");

      sweep(0, -1);
      sweep(1, -1);
      sweep(3, -1);
      sweep(2, -1);
      sweep(2, -1);

      sweep(0, 40);
      sweep(0, -1);
      chk("restart_checksum_zero", checksum, 128'(0));

      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", 128'(busy), 128'(0));
      tick();
      chk("start_abort_idle",  128'(busy),          128'(0));
      chk("start_abort_valid", 128'(bus.out_valid), 128'(0));

      // Single-word sweep on the DEPTH_MEM=1 instance.
      n_done2 = 0; done_at2 = -1; words2 = 0; cs2 = '0;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      bus2.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (done2) begin
            n_done2++;
            if (done_at2 < 0) done_at2 = c;
         end
         if (bus2.out_valid) begin
            chk("d1_addr", 128'(bus2.out_addr), 128'(0));
            chk("d1_data", bus2.out_data,       ram2[0]);
            cs2 = cs2 ^ ram2[0];
            words2++;
         end
         tick();
      end
      chk("d1_words",    128'(words2),   128'(1));
      chk("d1_done_once", 128'(n_done2), 128'(1));
      chk("d1_done_cyc", 128'(done_at2), 128'(3));
      chk("d1_checksum", checksum2,      cs2);

      // Reset in the middle of a sweep.
      start = 1'b1;
      tick();
      start = 1'b0;
      bus.out_ready = 1'b1;
      repeat (15) tick();
      chk("mid_busy_before_reset", 128'(busy), 128'(1));
      reset = 1'b1;
      tick();
      chk_reset_outputs("mid_reset");
      reset = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      chk("mid_reset_idle", 128'(busy), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
